// File: rtl/i2c_sample_datapath_if.sv
// Bundle between the I2C listener FSM (master) and its sampling datapath (slave).
// Carries the shift/count controls and the registered readback.
interface i2c_sample_datapath_if #(
    parameter int WIDTH     = 9,
    parameter int CNT_WIDTH = 8
);
    logic                 serial_in;
    logic                 shift_en;
    logic                 cnt_en;
    logic                 cnt_clr;
    logic [WIDTH-1:0]     shift_out;
    logic [CNT_WIDTH-1:0] count;
    logic                 count_last;

    modport master (
        output serial_in, shift_en, cnt_en, cnt_clr,
        input  shift_out, count, count_last
    );

    modport slave (
        input  serial_in, shift_en, cnt_en, cnt_clr,
        output shift_out, count, count_last
    );
endinterface

// File: rtl/i2c_sample_datapath.sv
// Purpose: SDA capture shift register (MSB first, ACK last in LSB) plus frame bit counter.
// Latency: one cycle from enables to shift_out/count; count_last is a same-cycle decode of count.
// Backpressure: none, the FSM drives enables every cycle and the datapath always accepts.
module i2c_sample_datapath #(
    parameter int WIDTH     = 9,
    parameter int CNT_WIDTH = 8
) (
    input  logic                  sysclk,
    input  logic                  rst,
    i2c_sample_datapath_if.slave  dp
);

    logic [WIDTH-1:0]     shift_q = '0;
    logic [WIDTH-1:0]     shift_d;
    logic [CNT_WIDTH-1:0] count_q = '0;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        shift_d = shift_q;
        if (dp.shift_en) begin
            shift_d = {shift_q[WIDTH-2:0], dp.serial_in};
        end
    end

    // Clear wins over increment; increment wraps modulo 2^CNT_WIDTH.
    always_comb begin
        count_d = count_q;
        if (dp.cnt_clr) begin
            count_d = '0;
        end else if (dp.cnt_en) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign dp.shift_out  = shift_q;
    assign dp.count      = count_q;
    // High while the last bit of the frame is being sampled.
    assign dp.count_last = (count_q == CNT_WIDTH'(WIDTH - 1));

endmodule

// File: tb/tb_i2c_sample_datapath.sv
// Randomized and directed checks of i2c_sample_datapath against an arithmetic reference model.
module tb_i2c_sample_datapath;

    localparam int W  = 9;
    localparam int CW = 8;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: register value and count as plain integers.
    int m_sr  = 0;
    int m_cnt = 0;

    i2c_sample_datapath_if #(.WIDTH(W), .CNT_WIDTH(CW)) dp_if ();

    i2c_sample_datapath #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .dp     (dp_if)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance the model with the inputs currently applied, then clock the DUT.
    task automatic tick();
        if (rst) begin
            m_sr  = 0;
            m_cnt = 0;
        end else begin
            if (dp_if.shift_en)
                m_sr = (m_sr * 2 + int'(dp_if.serial_in)) % (1 << W);
            if (dp_if.cnt_clr)
                m_cnt = 0;
            else if (dp_if.cnt_en)
                m_cnt = (m_cnt + 1) % (1 << CW);
        end
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s_en, input logic c_en,
                         input logic c_clr, input logic sin);
        rst             = r;
        dp_if.shift_en  = s_en;
        dp_if.cnt_en    = c_en;
        dp_if.cnt_clr   = c_clr;
        dp_if.serial_in = sin;
    endtask

    task automatic test_powerup();
        #1;
        n_cmp++;
        if (dp_if.shift_out !== '0 || dp_if.count !== '0) begin
            n_err++;
            $display("FAIL powerup: shift_out=%h count=%0d required 000/0", dp_if.shift_out, dp_if.count);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (dp_if.shift_out !== 9'h000) begin
            n_err++;
            $display("FAIL reset_shift: got %h required 000", dp_if.shift_out);
        end
        n_cmp++;
        if (dp_if.count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d required 0", dp_if.count);
        end
        n_cmp++;
        if (dp_if.count_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_count_last: got %b required 0", dp_if.count_last);
        end
    endtask

    task automatic test_byte_capture();
        logic [8:0] bits;
        bits = 9'b1_0100_1010;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, bits[8-i]);
            #1;
            n_cmp++;
            if (dp_if.count_last !== (m_cnt == W - 1) || dp_if.count_last !== (i == 8)) begin
                n_err++;
                $display("FAIL byte_count_last[%0d]: got %b count=%0d", i, dp_if.count_last, dp_if.count);
            end
            tick();
        end
        n_cmp++;
        if (dp_if.shift_out !== 9'h14A || dp_if.shift_out !== W'(m_sr)) begin
            n_err++;
            $display("FAIL byte_shift: got %h required 14A", dp_if.shift_out);
        end
        n_cmp++;
        if (dp_if.count !== 8'd9) begin
            n_err++;
            $display("FAIL byte_count: got %0d required 9", dp_if.count);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'(i));
            tick();
            n_cmp++;
            if (dp_if.shift_out !== 9'h14A || dp_if.count !== 8'd9) begin
                n_err++;
                $display("FAIL hold[%0d]: shift_out=%h count=%0d required 14A/9", i, dp_if.shift_out, dp_if.count);
            end
        end
    endtask

    task automatic test_clear_priority();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        n_cmp++;
        if (dp_if.count !== 8'd5) begin
            n_err++;
            $display("FAIL clr_setup: count=%0d required 5", dp_if.count);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        n_cmp++;
        if (dp_if.count !== 8'd0 || dp_if.shift_out !== W'(m_sr)) begin
            n_err++;
            $display("FAIL clr_over_en: count=%0d shift_out=%h required 0/%h", dp_if.count, dp_if.shift_out, W'(m_sr));
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        n_cmp++;
        if (dp_if.count !== 8'd3) begin
            n_err++;
            $display("FAIL clr_then_count: count=%0d required 3", dp_if.count);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 255) begin
                n_cmp++;
                if (dp_if.count !== 8'd255 || dp_if.count_last !== 1'b0) begin
                    n_err++;
                    $display("FAIL wrap_at_255: count=%0d count_last=%b required 255/0", dp_if.count, dp_if.count_last);
                end
            end
            tick();
            n_cmp++;
            if (dp_if.count !== CW'(m_cnt)) begin
                n_err++;
                $display("FAIL wrap_step[%0d]: count=%0d required %0d", i, dp_if.count, m_cnt);
            end
        end
        n_cmp++;
        if (dp_if.count !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_final: count=%0d required 0", dp_if.count);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            tick();
        end
        n_cmp++;
        if (dp_if.shift_out !== 9'h00F || dp_if.count !== 8'd4) begin
            n_err++;
            $display("FAIL midrst_setup: shift_out=%h count=%0d required 00F/4", dp_if.shift_out, dp_if.count);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (dp_if.shift_out !== 9'h000 || dp_if.count !== 8'd0) begin
            n_err++;
            $display("FAIL midrst_clear: shift_out=%h count=%0d required 000/0", dp_if.shift_out, dp_if.count);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (dp_if.shift_out !== 9'h002 || dp_if.count !== 8'd2) begin
            n_err++;
            $display("FAIL midrst_resume: shift_out=%h count=%0d required 002/2", dp_if.shift_out, dp_if.count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) == 0), 1'($urandom));
            #1;
            n_cmp++;
            if (dp_if.count_last !== (m_cnt == W - 1)) begin
                n_err++;
                $display("FAIL rand_count_last[%0d]: got %b count=%0d", i, dp_if.count_last, dp_if.count);
            end
            tick();
            n_cmp++;
            if (dp_if.shift_out !== W'(m_sr) || dp_if.count !== CW'(m_cnt)) begin
                n_err++;
                $display("FAIL rand_state[%0d]: shift_out=%h count=%0d required %h/%0d",
                         i, dp_if.shift_out, dp_if.count, W'(m_sr), m_cnt);
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        test_powerup();
        test_reset();
        test_byte_capture();
        test_hold();
        test_clear_priority();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_sample_datapath.md
Name: i2c_sample_datapath

Overview:
Sampling datapath for the passive I2C bus listener. It combines two sub-blocks behind one wrapper:
- a serial-in/parallel-out shift register that captures SDA bits, MSB first, with the ACK/NAK bit landing last in the LSB;
- an up counter that counts the bits sampled in the current frame.

The listener FSM drives the enables and clears and reads back the parallel word and the bit count. The block has no bus-facing logic.

Parameters:
- WIDTH, 9, shift-register length in bits (8 data bits + 1 ACK/NAK); must be >= 2.
- CNT_WIDTH, 8, counter width in bits; must satisfy 2^CNT_WIDTH > WIDTH.

Ports:
- sysclk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset of all state.
- serial_in  input  1  serial data bit (SDA sample).
- shift_en  input  1  when high, shift serial_in into the register this cycle.
- cnt_en  input  1  when high, increment the counter this cycle.
- cnt_clr  input  1  synchronous counter clear.
- shift_out  output  WIDTH  parallel register contents (registered).
- count  output  CNT_WIDTH  current counter value (registered).
- count_last  output  1  combinational; high when count == WIDTH-1.

Behaviour:
Reset:
- rst high at a clock edge: shift_out <= 0 and count <= 0.
- rst overrides every other input, including a simultaneous shift_en, cnt_en or cnt_clr.
- With count = 0 after reset, count_last = 0.
- No asynchronous behaviour.
- Initial power-up value of all registers is 0.

Shift register:
- On an edge with shift_en=1 and rst=0: shift_out <= {shift_out[WIDTH-2:0], serial_in}.
  - The oldest bit moves toward the MSB; the newest bit enters at the LSB.
  - After exactly WIDTH shifts, the first bit shifted is at bit WIDTH-1 and the last bit is at bit 0.
- shift_en=0: shift_out holds.
- The register never clears except by rst; old bits simply shift out of the MSB.
- Latency: one cycle from serial_in/shift_en to shift_out.

Counter:
- Priority per edge: rst > cnt_clr > cnt_en.
- cnt_clr=1: count <= 0, even if cnt_en=1.
- cnt_en=1 with cnt_clr=0: count <= count + 1, modulo 2^CNT_WIDTH.
  - 2^CNT_WIDTH-1 wraps to 0, with no saturation and no carry out.
- Otherwise count holds.
- The counter is independent of shift_en; the two enables may be asserted separately or together.

count_last:
- Purely combinational decode of the registered count: count == WIDTH-1.
- No additional latency.
- Used by the FSM during the sampling cycle, where count equals the number of bits already sampled before this one.
- It is therefore high on the cycle the WIDTH-th bit is being shifted.

General:
- No handshakes, no internal state beyond the two registers.
- Outputs are never X after the first clock edge.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with shift_en=cnt_en=1 and serial_in=1 → shift_out=9'h000, count=0, count_last=0.
2. Byte capture: shift in 1,0,1,0,0,1,0,1 then ACK=0, with shift_en and cnt_en high together for 9 consecutive cycles.
   - Every cycle, count_last equals (count == 8); it is high on the 9th cycle, when count=8.
   - Final state: shift_out=9'h14A, count=9.
3. Hold: after case 2, deassert both enables for 5 cycles with serial_in toggling → shift_out stays 9'h14A, count stays 9.
4. Clear priority:
   - count=5, apply cnt_clr=1 and cnt_en=1 together → count=0 next cycle and shift_out unchanged.
   - Then cnt_en alone for 3 cycles → count=3.
5. Wrap-around: 256 consecutive cnt_en cycles from count=0 → count=0 again. At count=255 plus one increment → 0, and count_last=0 at 255.
6. Mid-operation reset: after 4 shifts of 1 (shift_out=9'h00F, count=4), assert rst concurrently with shift_en and cnt_en → next cycle shift_out=0, count=0. Shifting resumes normally once rst=0.
